// File: rtl/debounce_pkg.sv
// ============================================================================
// debounce_pkg : FSM state encoding shared by the debounce_sync block
// Rev 1.0
// ============================================================================
`default_nettype none

package debounce_pkg;

  localparam logic [1:0] ST_STABLE_LO = 2'd0;
  localparam logic [1:0] ST_CHECK_HI  = 2'd1;
  localparam logic [1:0] ST_STABLE_HI = 2'd2;
  localparam logic [1:0] ST_CHECK_LO  = 2'd3;

  function automatic logic [1:0] stable_state(input logic level);
    return level ? ST_STABLE_HI : ST_STABLE_LO;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ff_chain.sv
// ============================================================================
// sync_ff_chain : N-flop synchroniser for one asynchronous input bit
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_ff_chain #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_LEVEL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/debounce_sync.sv
// ============================================================================
// debounce_sync : synchronise, debounce and edge-detect a raw async input
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_sync
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   CNT_W           = 16,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  output logic y,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("debounce_sync: SYNC_STAGES must be >= 2");
  end
  if ((DEBOUNCE_CYCLES < 2) ||
      (64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_debounce_cycles
    $error("debounce_sync: DEBOUNCE_CYCLES must be in 2..2**CNT_W-1");
  end

  logic             s;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             y_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  sync_ff_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (a),
    .q     (s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= stable_state(RESET_LEVEL);
      cnt   <= '0;
      y     <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      y     <= y_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // A sample back at the old level abandons qualification; the count restarts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_STABLE_LO: begin
        if (s) begin
          state_nxt = ST_CHECK_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_CHECK_HI: begin
        if (!s) begin
          state_nxt = ST_STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_STABLE_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_STABLE_HI: begin
        if (!s) begin
          state_nxt = ST_CHECK_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_CHECK_LO: begin
        if (s) begin
          state_nxt = ST_STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_STABLE_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = stable_state(RESET_LEVEL);
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    rise_nxt = (state == ST_CHECK_HI) && (state_nxt == ST_STABLE_HI);
    fall_nxt = (state == ST_CHECK_LO) && (state_nxt == ST_STABLE_LO);
    y_nxt    = y;
    if (rise_nxt) begin
      y_nxt = 1'b1;
    end else if (fall_nxt) begin
      y_nxt = 1'b0;
    end
  end

  assign busy = (state == ST_CHECK_HI) || (state == ST_CHECK_LO);

endmodule

`default_nettype wire

// File: tb/tb_debounce_sync.sv
// ============================================================================
// tb_debounce_sync : scoreboard bench for debounce_sync against a run-length model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_debounce_sync;

  localparam int   S  = 2;
  localparam int   D  = 4;
  localparam logic RL = 1'b0;

  typedef struct packed {
    logic y;
    logic rise;
    logic fall;
    logic busy;
  } out_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic a     = 1'b1;
  logic y, rise, fall, busy;

  out_t expq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   rise_seen   = 0;
  int   fall_seen   = 0;
  int   busy_seen   = 0;

  // Reference model: delay line of raw samples plus a run length of samples
  // disagreeing with the current debounced level.
  logic m_pipe[S];
  logic m_y;
  int   m_run;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES     (S),
    .CNT_W           (16),
    .DEBOUNCE_CYCLES (D),
    .RESET_LEVEL     (RL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .y     (y),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  function automatic out_t reset_out();
    out_t e;
    e   = '0;
    e.y = RL;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_pipe[i] = RL;
    m_y   = RL;
    m_run = 0;
  endtask

  task automatic model_edge(input logic av, output out_t e);
    logic s;
    s = m_pipe[S-1];
    for (int i = S-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = av;
    e = '0;
    if (s != m_y) begin
      m_run++;
      if (m_run == D) begin
        m_y    = s;
        e.rise = s;
        e.fall = !s;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    e.y    = m_y;
    e.busy = (m_run != 0);
  endtask

  task automatic cyc(input logic av, input logic rv = 1'b1);
    out_t e;
    @(negedge clk);
    a     = av;
    rst_n = rv;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      e = reset_out();
    end else begin
      model_edge(a, e);
    end
    expq.push_back(e);
  endtask

  task automatic hold(input logic av, input int n);
    for (int i = 0; i < n; i++) cyc(av);
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every cycle is an output cycle, compared against the queued response.
  initial begin
    out_t e;
    out_t got;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        got = {y, rise, fall, busy};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL cycle_check t=%0t: got y=%b rise=%b fall=%b busy=%b, expected y=%b rise=%b fall=%b busy=%b",
                   $time, got.y, got.rise, got.fall, got.busy, e.y, e.rise, e.fall, e.busy);
        end
        if (rise && fall) begin
          miscompares++;
          $display("FAIL rise_fall_exclusive t=%0t: got rise=1 fall=1, expected at most one", $time);
        end
        if (rise === 1'b1) rise_seen++;
        if (fall === 1'b1) fall_seen++;
        if (busy === 1'b1) busy_seen++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, f0, b0, n;
    logic v;
    model_reset();

    // 1: reset with a=1, then release and qualify the high level
    #2;
    chk("reset_y", int'(y), int'(RL));
    chk("reset_rise_fall_busy", int'({rise, fall, busy}), 0);
    hold(1'b1, 0);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    r0 = rise_seen;
    hold(1'b1, 10);
    drain();
    chk("release_rise_count", rise_seen - r0, 1);
    chk("release_y", int'(y), 1);

    // 2: short high pulse rejected as a glitch
    hold(1'b0, 10);
    drain();
    r0 = rise_seen; b0 = busy_seen;
    hold(1'b1, 3);
    hold(1'b0, 8);
    drain();
    chk("glitch_rise_count", rise_seen - r0, 0);
    chk("glitch_busy_cycles", busy_seen - b0, 3);
    chk("glitch_y", int'(y), 0);

    // 3: clean rise and fall
    r0 = rise_seen; f0 = fall_seen;
    hold(1'b1, 20);
    hold(1'b0, 20);
    drain();
    chk("clean_rise_count", rise_seen - r0, 1);
    chk("clean_fall_count", fall_seen - f0, 1);

    // 4: bounce every 2 cycles, then settle high
    r0 = rise_seen; f0 = fall_seen;
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 1'b1 : 1'b0, 2);
    hold(1'b1, 12);
    drain();
    chk("bounce_rise_count", rise_seen - r0, 1);
    chk("bounce_fall_count", fall_seen - f0, 0);
    chk("bounce_y", int'(y), 1);

    // 5: async reset while qualifying a rise
    hold(1'b0, 10);
    hold(1'b1, 3);
    #1;
    chk("pre_reset_busy", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({y, rise, fall, busy}), 0);
    void'(expq.pop_back());
    model_reset();
    expq.push_back(reset_out());
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    r0 = rise_seen; f0 = fall_seen;
    hold(1'b0, 10);
    drain();
    chk("post_reset_pulses", (rise_seen - r0) + (fall_seen - f0), 0);

    // 6: random runs of a against the model
    n = 0;
    while (n < 3000) begin
      int len;
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      hold(v, len);
      n += len;
    end
    hold(1'b0, 10);
    drain();
    drain();
    chk("queue_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
